// File: rtl/audio_clk_switch_seq.sv
// -----------------------------------------------------------------------------
// audio_clk_switch_seq
// Glitch-free, click-free audio master clock source switch sequencer.
// Sequence per request: mute -> gate clock -> switch mux -> wait lock/settle
// -> ungate -> unmute. Sole driver of the clock mux select and clock gate.
// After reset the block starts in WAIT_LOCK on source 0, so power-up runs the
// lock/settle/ungate/unmute tail by itself.
//
// Ports:
//   clock        system clock (single domain)
//   reset        synchronous, active-high reset
//   req_valid    switch request strobe
//   req_sel      requested source index
//   req_ready    high only in IDLE
//   pll_locked   per-source PLL lock (already synchronised)
//   mute_ack     audio path reports muted
//   mute_req     request audio mute
//   clk_gate_en  enable for the gated audio clock
//   clk_sel      clock mux select
//   busy         sequencer not in IDLE
//   done         one-cycle pulse when a sequence completes
//   err          sticky error, cleared by an accepted request
//   err_code     0 none, 1 bad sel, 2 mute timeout, 3 lock timeout
//   switch_cnt   (AUDIO_CLK_SEQ_SWITCH_CNT_EN only) saturating count of
//                completed sequences that actually changed the select
//
// Optional feature macro: AUDIO_CLK_SEQ_SWITCH_CNT_EN
// -----------------------------------------------------------------------------
module audio_clk_switch_seq #(
    parameter int unsigned NUM_SRC       = 2,
    parameter int unsigned SEL_W         = 2,
    parameter int unsigned GATE_CYCLES   = 4,
    parameter int unsigned SETTLE_CYCLES = 64,
    parameter int unsigned LOCK_TIMEOUT  = 4096,
    parameter int unsigned MUTE_TIMEOUT  = 1024
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               req_valid,
    input  logic [SEL_W-1:0]   req_sel,
    output logic               req_ready,
    input  logic [NUM_SRC-1:0] pll_locked,
    input  logic               mute_ack,
    output logic               mute_req,
    output logic               clk_gate_en,
    output logic [SEL_W-1:0]   clk_sel,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [1:0]         err_code
`ifdef AUDIO_CLK_SEQ_SWITCH_CNT_EN
    ,
    output logic [15:0]        switch_cnt
`endif
);

    localparam int unsigned MAX_A   = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int unsigned MAX_B   = (LOCK_TIMEOUT > MUTE_TIMEOUT) ? LOCK_TIMEOUT : MUTE_TIMEOUT;
    localparam int unsigned MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;
    localparam int unsigned LOCK_W  = 1 << SEL_W;

    // Terminal counts: "hold N cycles" means leave on the N-th cycle in state.
    localparam logic [CNT_W-1:0] GATE_LAST   = CNT_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] MUTE_LAST   = CNT_W'(MUTE_TIMEOUT - 1);

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_BAD_SEL = 2'd1;
    localparam logic [1:0] ERR_MUTE_TO = 2'd2;
    localparam logic [1:0] ERR_LOCK_TO = 2'd3;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        MUTE      = 4'd1,
        WAIT_MUTE = 4'd2,
        GATE_OFF  = 4'd3,
        SWITCH    = 4'd4,
        HOLD      = 4'd5,
        WAIT_LOCK = 4'd6,
        SETTLE    = 4'd7,
        UNGATE    = 4'd8,
        UNMUTE    = 4'd9,
        FAULT     = 4'd10
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_inc;
    logic [SEL_W-1:0]   next_sel;
    logic               sel_changed;
    logic [LOCK_W-1:0]  lock_pad;
    logic               cur_locked;
    logic               req_bad;
    logic               req_same;

    // Zero-extend lock vector so any select value indexes safely.
    assign lock_pad   = LOCK_W'(pll_locked);
    assign cur_locked = lock_pad[clk_sel];

    assign req_bad  = 32'(req_sel) >= NUM_SRC;
    assign req_same = (req_sel == clk_sel);

    // Shared saturating cycle counter increment.
    assign cnt_inc = (&cnt) ? cnt : cnt + CNT_W'(1);

    // Sequencer FSM; every state entry clears the shared counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= WAIT_LOCK;
            cnt         <= '0;
            next_sel    <= '0;
            sel_changed <= 1'b0;
            clk_sel     <= '0;
            clk_gate_en <= 1'b0;
            mute_req    <= 1'b1;
            done        <= 1'b0;
            err         <= 1'b0;
            err_code    <= ERR_NONE;
            busy        <= 1'b1;
            req_ready   <= 1'b0;
        end else begin
            done <= 1'b0;
            cnt  <= cnt_inc;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        err      <= 1'b0;
                        err_code <= ERR_NONE;
                        if (req_bad) begin
                            err      <= 1'b1;
                            err_code <= ERR_BAD_SEL;
                        end else if (req_same) begin
                            done <= 1'b1;
                        end else begin
                            next_sel  <= req_sel;
                            state     <= MUTE;
                            cnt       <= '0;
                            busy      <= 1'b1;
                            req_ready <= 1'b0;
                        end
                    end
                end
                MUTE: begin
                    mute_req <= 1'b1;
                    state    <= WAIT_MUTE;
                    cnt      <= '0;
                end
                WAIT_MUTE: begin
                    if (mute_ack) begin
                        clk_gate_en <= 1'b0;
                        state       <= GATE_OFF;
                        cnt         <= '0;
                    end else if (cnt == MUTE_LAST) begin
                        // Give up without touching the clock; audio path unmuted.
                        mute_req  <= 1'b0;
                        err       <= 1'b1;
                        err_code  <= ERR_MUTE_TO;
                        state     <= IDLE;
                        cnt       <= '0;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                GATE_OFF: begin
                    clk_gate_en <= 1'b0;
                    if (cnt == GATE_LAST) begin
                        state <= SWITCH;
                        cnt   <= '0;
                    end
                end
                SWITCH: begin
                    clk_sel     <= next_sel;
                    sel_changed <= (next_sel != clk_sel);
                    state       <= HOLD;
                    cnt         <= '0;
                end
                HOLD: begin
                    if (cnt == GATE_LAST) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                    end
                end
                WAIT_LOCK: begin
                    if (cur_locked) begin
                        state <= SETTLE;
                        cnt   <= '0;
                    end else if (cnt == LOCK_LAST) begin
                        clk_gate_en <= 1'b0;
                        mute_req    <= 1'b1;
                        err         <= 1'b1;
                        err_code    <= ERR_LOCK_TO;
                        state       <= FAULT;
                        cnt         <= '0;
                    end
                end
                SETTLE: begin
                    // Any lock drop restarts the lock wait from scratch.
                    if (!cur_locked) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == SETTLE_LAST) begin
                        state <= UNGATE;
                        cnt   <= '0;
                    end
                end
                UNGATE: begin
                    clk_gate_en <= 1'b1;
                    state       <= UNMUTE;
                    cnt         <= '0;
                end
                UNMUTE: begin
                    mute_req  <= 1'b0;
                    done      <= 1'b1;
                    state     <= IDLE;
                    cnt       <= '0;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                end
                FAULT: begin
                    clk_gate_en <= 1'b0;
                    mute_req    <= 1'b1;
                    if (req_valid) begin
                        err      <= 1'b0;
                        err_code <= ERR_NONE;
                        if (req_bad) begin
                            err      <= 1'b1;
                            err_code <= ERR_BAD_SEL;
                        end else begin
                            // Already muted and gated: resume at the gate hold.
                            next_sel <= req_sel;
                            state    <= GATE_OFF;
                            cnt      <= '0;
                        end
                    end
                end
                default: begin
                    clk_gate_en <= 1'b0;
                    mute_req    <= 1'b1;
                    state       <= FAULT;
                    cnt         <= '0;
                end
            endcase
        end
    end

`ifdef AUDIO_CLK_SEQ_SWITCH_CNT_EN
    // Count completions that really moved the mux, saturating.
    always_ff @(posedge clock) begin
        if (reset) begin
            switch_cnt <= '0;
        end else if ((state == UNMUTE) && sel_changed && (switch_cnt != 16'hFFFF)) begin
            switch_cnt <= switch_cnt + 16'd1;
        end
    end
`else
    logic unused_sel_changed;
    assign unused_sel_changed = sel_changed;
`endif

endmodule

// File: tb/tb_audio_clk_switch_seq.sv
// -----------------------------------------------------------------------------
// tb_audio_clk_switch_seq
// Directed bench for audio_clk_switch_seq with GATE=4, SETTLE=8,
// LOCK_TIMEOUT=32, MUTE_TIMEOUT=16, NUM_SRC=2. Expected values are hand
// computed cycle counts from the sampling edge of each request.
// -----------------------------------------------------------------------------
module tb_audio_clk_switch_seq;

    logic       clock;
    logic       reset;
    logic       req_valid;
    logic [1:0] req_sel;
    logic       req_ready;
    logic [1:0] pll_locked;
    logic       mute_ack;
    logic       mute_req;
    logic       clk_gate_en;
    logic [1:0] clk_sel;
    logic       busy;
    logic       done;
    logic       err;
    logic [1:0] err_code;
`ifdef AUDIO_CLK_SEQ_SWITCH_CNT_EN
    logic [15:0] switch_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    audio_clk_switch_seq #(
        .NUM_SRC       (2),
        .SEL_W         (2),
        .GATE_CYCLES   (4),
        .SETTLE_CYCLES (8),
        .LOCK_TIMEOUT  (32),
        .MUTE_TIMEOUT  (16)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_sel     (req_sel),
        .req_ready   (req_ready),
        .pll_locked  (pll_locked),
        .mute_ack    (mute_ack),
        .mute_req    (mute_req),
        .clk_gate_en (clk_gate_en),
        .clk_sel     (clk_sel),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .err_code    (err_code)
`ifdef AUDIO_CLK_SEQ_SWITCH_CNT_EN
        ,
        .switch_cnt  (switch_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance n active edges, then settle 1 time unit for sampling/driving.
    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int early_done;
        int bad_gate;
        int sel_moves;
        logic [1:0] prev_sel;

        reset      = 1'b1;
        req_valid  = 1'b0;
        req_sel    = 2'd0;
        pll_locked = 2'b00;
        mute_ack   = 1'b0;

        // Reset values
        step(2);
        check("rst_clk_sel",  32'(clk_sel), 0);
        check("rst_gate",     32'(clk_gate_en), 0);
        check("rst_mute_req", 32'(mute_req), 1);
        check("rst_done",     32'(done), 0);
        check("rst_err",      32'(err), 0);
        check("rst_err_code", 32'(err_code), 0);
        check("rst_busy",     32'(busy), 1);
        check("rst_ready",    32'(req_ready), 0);

        // Power-up tail: lock on source 0 arrives after 4 edges
        reset = 1'b0;
        step(4);
        check("pu_wait_gate", 32'(clk_gate_en), 0);
        pll_locked = 2'b01;
        step(9);
        check("pu_gate_before", 32'(clk_gate_en), 0);
        step(1);
        check("pu_gate_on",    32'(clk_gate_en), 1);
        check("pu_still_mute", 32'(mute_req), 1);
        step(1);
        check("pu_unmute",  32'(mute_req), 0);
        check("pu_done",    32'(done), 1);
        check("pu_ready",   32'(req_ready), 1);
        check("pu_clk_sel", 32'(clk_sel), 0);
        step(1);
        check("pu_done_pulse", 32'(done), 0);

        // Normal switch 0 -> 1, done 22 cycles after the request edge
        mute_ack   = 1'b1;
        pll_locked = 2'b11;
        req_sel    = 2'd1;
        req_valid  = 1'b1;
        step(1);
        req_valid = 1'b0;
        check("sw1_busy",  32'(busy), 1);
        check("sw1_ready", 32'(req_ready), 0);
        early_done = 0;
        bad_gate   = 0;
        sel_moves  = 0;
        prev_sel   = clk_sel;
        for (int i = 1; i <= 21; i++) begin
            step(1);
            if (done) early_done++;
            if (clk_sel !== prev_sel) begin
                sel_moves++;
                if (clk_gate_en !== 1'b0) bad_gate++;
            end
            prev_sel = clk_sel;
        end
        check("sw1_no_early_done", 32'(early_done), 0);
        check("sw1_sel_moves",     32'(sel_moves), 1);
        check("sw1_gated_on_move", 32'(bad_gate), 0);
        check("sw1_gate_before_unmute", 32'(clk_gate_en), 1);
        check("sw1_mute_before_unmute", 32'(mute_req), 1);
        step(1);
        check("sw1_done",     32'(done), 1);
        check("sw1_clk_sel",  32'(clk_sel), 1);
        check("sw1_gate",     32'(clk_gate_en), 1);
        check("sw1_mute_req", 32'(mute_req), 0);
        check("sw1_busy_end", 32'(busy), 0);

        // Same select: immediate done, no mute
        req_sel   = 2'd1;
        req_valid = 1'b1;
        step(1);
        req_valid = 1'b0;
        check("same_done",  32'(done), 1);
        check("same_mute",  32'(mute_req), 0);
        check("same_busy",  32'(busy), 0);
        check("same_ready", 32'(req_ready), 1);
        step(1);
        check("same_done_pulse", 32'(done), 0);

        // Bad select
        req_sel   = 2'd3;
        req_valid = 1'b1;
        step(1);
        req_valid = 1'b0;
        check("bad_err",      32'(err), 1);
        check("bad_err_code", 32'(err_code), 1);
        check("bad_clk_sel",  32'(clk_sel), 1);
        check("bad_done",     32'(done), 0);
        check("bad_ready",    32'(req_ready), 1);

        // Second real switch 1 -> 0, also clears the sticky error
        req_sel   = 2'd0;
        req_valid = 1'b1;
        step(1);
        req_valid = 1'b0;
        check("sw0_err_clr", 32'(err), 0);
        step(21);
        check("sw0_not_yet", 32'(done), 0);
        step(1);
        check("sw0_done",    32'(done), 1);
        check("sw0_clk_sel", 32'(clk_sel), 0);

        // Mute timeout: mute_ack held low
        mute_ack  = 1'b0;
        req_sel   = 2'd1;
        req_valid = 1'b1;
        step(1);
        req_valid = 1'b0;
        check("mto_busy", 32'(busy), 1);
        step(16);
        check("mto_waiting_mute", 32'(mute_req), 1);
        check("mto_waiting_err",  32'(err), 0);
        step(1);
        check("mto_err",      32'(err), 1);
        check("mto_err_code", 32'(err_code), 2);
        check("mto_mute_req", 32'(mute_req), 0);
        check("mto_ready",    32'(req_ready), 1);
        check("mto_clk_sel",  32'(clk_sel), 0);
        check("mto_gate",     32'(clk_gate_en), 1);

        // Lock loss mid-settle, then lock timeout into FAULT
        mute_ack   = 1'b1;
        pll_locked = 2'b11;
        req_sel    = 2'd1;
        req_valid  = 1'b1;
        step(1);
        req_valid = 1'b0;
        step(15);
        pll_locked = 2'b01;
        step(1);
        check("ll_gate_off", 32'(clk_gate_en), 0);
        check("ll_busy",     32'(busy), 1);
        step(6);
        check("ll_no_done",  32'(done), 0);
        check("ll_still_gated", 32'(clk_gate_en), 0);
        step(25);
        check("lto_not_yet", 32'(err), 0);
        step(1);
        check("lto_err",      32'(err), 1);
        check("lto_err_code", 32'(err_code), 3);
        check("lto_gate",     32'(clk_gate_en), 0);
        check("lto_mute_req", 32'(mute_req), 1);
        check("lto_ready",    32'(req_ready), 0);
        check("lto_clk_sel",  32'(clk_sel), 1);

        // Recovery from FAULT onto source 0 (restarts at the gate hold)
        req_sel   = 2'd0;
        req_valid = 1'b1;
        step(1);
        req_valid = 1'b0;
        check("rec_err_clr",  32'(err), 0);
        check("rec_code_clr", 32'(err_code), 0);
        step(19);
        check("rec_not_yet", 32'(done), 0);
        check("rec_gate_on", 32'(clk_gate_en), 1);
        step(1);
        check("rec_done",     32'(done), 1);
        check("rec_clk_sel",  32'(clk_sel), 0);
        check("rec_err",      32'(err), 0);
        check("rec_mute_req", 32'(mute_req), 0);
`ifdef AUDIO_CLK_SEQ_SWITCH_CNT_EN
        check("cnt_three", 32'(switch_cnt), 3);
`endif

        // Reset in WAIT_LOCK (source 1 never locks)
        req_sel   = 2'd1;
        req_valid = 1'b1;
        step(1);
        req_valid = 1'b0;
        step(13);
        check("mid_clk_sel", 32'(clk_sel), 1);
        check("mid_gate",    32'(clk_gate_en), 0);
        reset = 1'b1;
        step(1);
        check("mrst_clk_sel",  32'(clk_sel), 0);
        check("mrst_gate",     32'(clk_gate_en), 0);
        check("mrst_mute_req", 32'(mute_req), 1);
        check("mrst_done",     32'(done), 0);
        check("mrst_err",      32'(err), 0);
        check("mrst_busy",     32'(busy), 1);
`ifdef AUDIO_CLK_SEQ_SWITCH_CNT_EN
        check("mrst_cnt", 32'(switch_cnt), 0);
`endif
        reset = 1'b0;
        step(11);
        check("mrst_tail_done",    32'(done), 1);
        check("mrst_tail_clk_sel", 32'(clk_sel), 0);
        check("mrst_tail_gate",    32'(clk_gate_en), 1);
        check("mrst_tail_mute",    32'(mute_req), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/audio_clk_switch_seq.md
Name: audio_clk_switch_seq

Overview:
Sequencer that performs glitch-free, click-free switching of the audio master clock between PLL sources (e.g. 48 kHz family vs 44.1 kHz family). It accepts a source-select request from the AXI4-Lite register file and runs a fixed sequence:
- mute the audio path
- gate the clock
- switch the mux select
- wait for PLL lock and settle
- ungate the clock
- unmute

It sits between the register block and the clock mux / I2S mute logic, and is the only driver of the mux select and clock gate.

Parameters:
NUM_SRC, 2, number of selectable clock sources (2..4)
SEL_W, 2, width of select fields
GATE_CYCLES, 4, cycles clock stays gated before and after select change
SETTLE_CYCLES, 64, cycles waited after lock before ungating
LOCK_TIMEOUT, 4096, max cycles waiting for pll_locked
MUTE_TIMEOUT, 1024, max cycles waiting for mute_ack

Ports:
clock  in  1  system clock; single clock domain
reset  in  1  synchronous, active-high reset
req_valid  in  1  switch request strobe
req_sel  in  SEL_W  requested source index
req_ready  out  1  high only in IDLE
pll_locked  in  NUM_SRC  per-source lock, pre-synchronised
mute_ack  in  1  audio path reports muted
mute_req  out  1  request audio mute
clk_gate_en  out  1  enable for gated audio clock
clk_sel  out  SEL_W  clock mux select
busy  out  1  state != IDLE
done  out  1  one-cycle pulse on sequence completion
err  out  1  sticky error; cleared by accepted request
err_code  out  2  0 none, 1 bad sel, 2 mute timeout, 3 lock timeout

Behaviour:
- Reset values: clk_sel=0, clk_gate_en=0, mute_req=1, done=0, err=0, err_code=0.
- After reset, state=WAIT_LOCK on source 0, so power-up runs the lock/settle/ungate/unmute tail automatically.
- States and transitions:
  - IDLE: req_ready=1. On req_valid, err/err_code are cleared first, then:
    - req_sel>=NUM_SRC -> err=1, err_code=1, stay IDLE.
    - req_sel==clk_sel -> done pulse next cycle, stay IDLE.
    - otherwise latch req_sel into next_sel -> MUTE.
  - MUTE: mute_req=1 -> WAIT_MUTE.
  - WAIT_MUTE: when mute_ack=1 -> GATE_OFF. If counter reaches MUTE_TIMEOUT -> mute_req=0, err=1, err_code=2, -> IDLE; clk_sel unchanged.
  - GATE_OFF: clk_gate_en=0; hold GATE_CYCLES cycles -> SWITCH.
  - SWITCH: clk_sel<=next_sel for one cycle -> HOLD.
  - HOLD: GATE_CYCLES cycles -> WAIT_LOCK.
  - WAIT_LOCK: when pll_locked[clk_sel]=1 -> SETTLE. If counter reaches LOCK_TIMEOUT -> FAULT, err=1, err_code=3.
  - SETTLE: SETTLE_CYCLES cycles. If pll_locked[clk_sel] drops at any point -> restart WAIT_LOCK with the counter cleared. Otherwise -> UNGATE.
  - UNGATE: clk_gate_en=1 -> UNMUTE.
  - UNMUTE: mute_req=0, done=1 (one cycle) -> IDLE.
  - FAULT: clk_gate_en=0, mute_req=1. req_valid accepted here as in IDLE; a valid new sel (including the current one) restarts at GATE_OFF.
- Counters: one shared counter, cleared on every state entry, width clog2 of the maximum parameter plus 1, no wrap.
- The cycle count N states "hold exactly N cycles".
- Minimum switch latency, req_valid to done, with mute_ack immediate and lock already high: 2*GATE_CYCLES + SETTLE_CYCLES + 6 cycles.
- req_valid outside IDLE/FAULT is ignored; there is no queueing.
- reset mid-sequence returns to the reset values and restarts the power-up tail on source 0.
- clk_sel never changes while clk_gate_en=1.

Optional Feature:
AUDIO_CLK_SEQ_SWITCH_CNT_EN:
- Defined: adds output switch_cnt[15:0], which increments on each done pulse caused by an actual select change, saturates at 16'hFFFF, and resets to 0.
- Undefined: the port and counter are absent.

Test Plan:
- Power-up: params GATE=4, SETTLE=8, LOCK_TIMEOUT=32, MUTE_TIMEOUT=16; reset, then pll_locked=2'b01 at cycle 5 -> clk_gate_en=1 at cycle 5+8+1, then mute_req=0 next cycle, clk_sel=0.
- Normal switch: req_sel=1, mute_ack=1 immediately, pll_locked=2'b11 -> done exactly 2*4+8+6=22 cycles after req_valid; clk_sel=1; clk_gate_en=0 throughout the clk_sel change.
- Same-sel and bad-sel: req_sel=1 while clk_sel=1 -> done next cycle with no mute. req_sel=3 with NUM_SRC=2 -> err=1, err_code=1, clk_sel unchanged.
- Mute timeout: mute_ack held 0 -> after 16 cycles in WAIT_MUTE, err_code=2, mute_req=0, IDLE, clk_sel unchanged.
- Lock loss and timeout: drop pll_locked[1] mid-SETTLE -> return to WAIT_LOCK. Keep it low for 32 cycles -> FAULT, err_code=3, clk_gate_en=0. Then req_sel=0 -> recovers, done, err=0.
- Reset mid-sequence and counter: assert reset in WAIT_LOCK -> outputs at reset values next cycle. With AUDIO_CLK_SEQ_SWITCH_CNT_EN, 3 real switches plus 1 same-sel request -> switch_cnt=3.
